eu_dispatch: RTL and testbench

- Sits directly upstream of the execution units (EUs) and feeds each EU's instruction-queue dispatch port.
- Accepts renamed instructions in program order from rename via a valid/ready handshake, buffers them in a 2-entry skid buffer, and issues at most one per cycle to an EU.
- Target EU is chosen round-robin among EUs that are enabled, not full and hold a free credit.
- Per-EU credit counters mirror each EU iqueue's occupancy, so dispatch never overruns a queue despite the registered dispatch outputs.

---
 rtl/eu_dispatch_pkg.sv | 22 ++
 rtl/eu_dispatch_rr_arbiter.sv | 31 +++
 rtl/eu_dispatch.sv | 111 +++++++++++
 tb/tb_eu_dispatch.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eu_dispatch_pkg.sv
// Shared types and defaults for the EU dispatch stage: iqueue entry layout,
// EU index type and the default EU count / iqueue depth exponent.
`ifndef EU_LOG2_IQUEUE_LENGTH
`define EU_LOG2_IQUEUE_LENGTH 2
`endif

package eu_dispatch_pkg;

   localparam int EU_NUM_UNITS          = 4;
   localparam int EU_LOG2_IQUEUE_LENGTH = `EU_LOG2_IQUEUE_LENGTH;

   typedef logic [$clog2(EU_NUM_UNITS)-1:0] type_eu_idx;

   typedef struct packed {
      logic [7:0] tag;
      logic [3:0] opcode;
      logic [5:0] dst_preg;
      logic [5:0] src1_preg;
      logic [5:0] src2_preg;
   } type_iqueue_entry;

endpackage

// File: rtl/eu_dispatch_rr_arbiter.sv
// Combinational round-robin picker: first eligible EU at or after the
// round-robin pointer, wrapping modulo NUM_EU.
module eu_dispatch_rr_arbiter #(
   parameter int NUM_EU = 4,
   parameter int IDXW   = $clog2(NUM_EU)
) (
   input  logic [NUM_EU-1:0] eligible,
   input  logic [IDXW-1:0]   rr,
   output logic [NUM_EU-1:0] grant,
   output logic [IDXW-1:0]   idx,
   output logic              any_grant
);

   int cand;

   always_comb begin
      grant     = '0;
      idx       = '0;
      any_grant = 1'b0;
      cand      = 0;
      for (int off = 0; off < NUM_EU; off++) begin
         cand = (int'(rr) + off) % NUM_EU;
         if (!any_grant && eligible[cand]) begin
            any_grant   = 1'b1;
            grant[cand] = 1'b1;
            idx         = IDXW'(cand);
         end
      end
   end

endmodule

// File: rtl/eu_dispatch.sv
// Dispatch stage: 2-entry skid buffer from rename, round-robin issue to the
// EU iqueues, with per-EU credits tracking each iqueue's free slots.
module eu_dispatch
   import eu_dispatch_pkg::*;
#(
   parameter int NUM_EU            = EU_NUM_UNITS,
   parameter int LOG2_QUEUE_LENGTH = EU_LOG2_IQUEUE_LENGTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush_i,
   input  type_iqueue_entry      in_instr_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [NUM_EU-1:0]     eu_enable_i,
   input  logic [NUM_EU-1:0]     eu_full_i,
   input  logic [NUM_EU-1:0]     eu_dequeue_i,
   output type_iqueue_entry      dispatched_instr_o [NUM_EU],
   output logic [NUM_EU-1:0]     dispatched_instr_valid_o,
   output logic [15:0]           dispatch_stall_cnt_o
);

   localparam int IDXW = $clog2(NUM_EU);
   localparam int CW   = LOG2_QUEUE_LENGTH + 1;
   localparam logic [CW-1:0] MAX_CREDIT = {1'b1, {LOG2_QUEUE_LENGTH{1'b0}}};

   type_iqueue_entry  buf_q [2];
   type_iqueue_entry  buf_d [2];
   logic [1:0]        count_q, count_d;
   logic [IDXW-1:0]   rr_q;
   logic [CW-1:0]     credit_q [NUM_EU];
   logic [NUM_EU-1:0] eligible, grant;
   logic [IDXW-1:0]   sel;
   logic              any_grant, fire, push;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_EU; i++)
         eligible[i] = eu_enable_i[i] && !eu_full_i[i] && (credit_q[i] != '0);
   end

   eu_dispatch_rr_arbiter #(
      .NUM_EU (NUM_EU),
      .IDXW   (IDXW)
   ) u_arb (
      .eligible  (eligible),
      .rr        (rr_q),
      .grant     (grant),
      .idx       (sel),
      .any_grant (any_grant)
   );

   assign fire = (count_q != 2'd0) && any_grant && !flush_i;
   assign push = in_valid_i && in_ready_o && !flush_i;

   // Head sits in slot 0; a pop shifts slot 1 down before any push lands
   always_comb begin
      buf_d   = buf_q;
      count_d = count_q;
      if (fire) begin
         buf_d[0] = buf_q[1];
         count_d  = count_q - 2'd1;
      end
      if (push) begin
         buf_d[count_d[0]] = in_instr_i;
         count_d           = count_d + 2'd1;
      end
      if (flush_i)
         count_d = 2'd0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q                  <= 2'd0;
         in_ready_o               <= 1'b1;
         rr_q                     <= '0;
         dispatched_instr_valid_o <= '0;
         dispatch_stall_cnt_o     <= 16'd0;
         for (int i = 0; i < 2; i++)
            buf_q[i] <= '0;
         for (int i = 0; i < NUM_EU; i++) begin
            dispatched_instr_o[i] <= '0;
            credit_q[i]           <= MAX_CREDIT;
         end
      end else begin
         buf_q                    <= buf_d;
         count_q                  <= count_d;
         in_ready_o               <= !count_d[1];
         dispatched_instr_valid_o <= fire ? grant : '0;
         if (fire) begin
            dispatched_instr_o[sel] <= buf_q[0];
            rr_q <= (sel == IDXW'(NUM_EU - 1)) ? '0 : sel + IDXW'(1);
         end
         if ((count_q != 2'd0) && !fire && (dispatch_stall_cnt_o != 16'hFFFF))
            dispatch_stall_cnt_o <= dispatch_stall_cnt_o + 16'd1;
         // A dequeue at full credit is illegal and leaves the count pinned
         for (int i = 0; i < NUM_EU; i++) begin
            if (fire && grant[i] && !eu_dequeue_i[i])
               credit_q[i] <= credit_q[i] - CW'(1);
            else if (eu_dequeue_i[i] && !(fire && grant[i]) && (credit_q[i] != MAX_CREDIT))
               credit_q[i] <= credit_q[i] + CW'(1);
         end
      end
   end

   for (genvar i = 0; i < NUM_EU; i++) begin : g_credit_check
      assert property (@(posedge clk) disable iff (reset)
         !(eu_dequeue_i[i] && !(fire && grant[i]) && (credit_q[i] == MAX_CREDIT)));
   end

endmodule

// File: tb/tb_eu_dispatch.sv
// Scoreboard bench for eu_dispatch: each accepted instruction pushes its
// expected EU and tag; a negedge monitor pops and compares on every dispatch.
module tb_eu_dispatch;
   import eu_dispatch_pkg::*;

   localparam int NEU = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             flush_i;
   type_iqueue_entry in_instr_i;
   logic             in_valid_i;
   logic             in_ready_o;
   logic [NEU-1:0]   eu_enable_i;
   logic [NEU-1:0]   eu_full_i;
   logic [NEU-1:0]   eu_dequeue_i;
   type_iqueue_entry dispatched_instr_o [NEU];
   logic [NEU-1:0]   dispatched_instr_valid_o;
   logic [15:0]      dispatch_stall_cnt_o;

   typedef struct {
      int         eu;
      logic [7:0] tag;
      int         acc;
   } exp_t;

   exp_t exp_q [$];
   int   lat_q [$];
   int   cyc = 0;
   int   compared = 0;
   int   mismatched = 0;

   eu_dispatch #(
      .NUM_EU            (NEU),
      .LOG2_QUEUE_LENGTH (1)
   ) dut (
      .clk                      (clk),
      .reset                    (reset),
      .flush_i                  (flush_i),
      .in_instr_i               (in_instr_i),
      .in_valid_i               (in_valid_i),
      .in_ready_o               (in_ready_o),
      .eu_enable_i              (eu_enable_i),
      .eu_full_i                (eu_full_i),
      .eu_dequeue_i             (eu_dequeue_i),
      .dispatched_instr_o       (dispatched_instr_o),
      .dispatched_instr_valid_o (dispatched_instr_valid_o),
      .dispatch_stall_cnt_o     (dispatch_stall_cnt_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   // Dispatch monitor: every valid must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!reset && dispatched_instr_valid_o != '0) begin
         if ($countones(dispatched_instr_valid_o) != 1)
            checkOutput("onehot", 32'($countones(dispatched_instr_valid_o)), 32'd1);
         else if (exp_q.size() == 0)
            checkOutput("spurious_valid", 32'(dispatched_instr_valid_o), 32'd0);
         else begin
            exp_t e;
            int   idx;
            e   = exp_q.pop_front();
            idx = 0;
            for (int i = 0; i < NEU; i++)
               if (dispatched_instr_valid_o[i]) idx = i;
            checkOutput("eu_sel", 32'(idx), 32'(e.eu));
            checkOutput("tag", 32'(dispatched_instr_o[idx].tag), 32'(e.tag));
            lat_q.push_back(cyc - e.acc);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      flush_i      = 1'b0;
      in_valid_i   = 1'b0;
      in_instr_i   = '0;
      eu_dequeue_i = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      lat_q.delete();
   endtask

   // Offer one instruction until accepted; eu < 0 means it must never dispatch here
   task automatic applyStimulus(input logic [7:0] tag, input int eu);
      logic accepted;
      int   acc_cyc;
      accepted   = 1'b0;
      acc_cyc    = 0;
      in_instr_i = '{tag: tag, opcode: 4'h5, dst_preg: tag[5:0], src1_preg: ~tag[5:0], src2_preg: 6'h2A};
      in_valid_i = 1'b1;
      for (int g = 0; g < 64 && !accepted; g++) begin
         @(negedge clk);
         accepted = in_ready_o;
         acc_cyc  = cyc;
         @(posedge clk);
         #1;
      end
      in_valid_i = 1'b0;
      if (!accepted)
         checkOutput("accept_timeout", 32'd0, 32'd1);
      else if (eu >= 0)
         exp_q.push_back('{eu: eu, tag: tag, acc: acc_cyc});
   endtask

   task automatic wait_drain(input string tag);
      for (int g = 0; g < 50 && exp_q.size() != 0; g++)
         next_cycle();
      next_cycle();
      checkOutput(tag, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic expect_idle(input string tag, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         checkOutput(tag, 32'(dispatched_instr_valid_o), 32'd0);
         next_cycle();
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      eu_enable_i = '1;
      eu_full_i   = '0;
      do_reset();

      // reset values
      @(negedge clk);
      checkOutput("rst_ready", 32'(in_ready_o), 32'd1);
      checkOutput("rst_valid", 32'(dispatched_instr_valid_o), 32'd0);
      checkOutput("rst_stall", 32'(dispatch_stall_cnt_o), 32'd0);
      checkOutput("rst_dout0", 32'(dispatched_instr_o[0]), 32'd0);
      checkOutput("rst_dout3", 32'(dispatched_instr_o[3]), 32'd0);
      next_cycle();

      // back-to-back round robin across all EUs
      for (int t = 1; t <= 6; t++)
         applyStimulus(8'(t), (t - 1) % NEU);
      wait_drain("rr_drain");
      checkOutput("rr_lat_count", 32'(lat_q.size()), 32'd6);
      for (int i = 0; i < lat_q.size(); i++)
         checkOutput("rr_latency", 32'(lat_q[i]), 32'd2);
      checkOutput("rr_stall", 32'(dispatch_stall_cnt_o), 32'd0);

      // two credits on EU2 only, released by a single dequeue
      do_reset();
      eu_enable_i = 4'b0100;
      applyStimulus(8'd1, 2);
      applyStimulus(8'd2, 2);
      applyStimulus(8'd3, 2);
      applyStimulus(8'd4, -1);
      @(negedge clk);
      checkOutput("cred_ready_low", 32'(in_ready_o), 32'd0);
      next_cycle();
      expect_idle("cred_hold", 3);
      checkOutput("cred_pending", 32'(exp_q.size()), 32'd1);
      eu_dequeue_i = 4'b0100;
      next_cycle();
      eu_dequeue_i = 4'b0000;
      @(negedge clk);
      checkOutput("deq_lat", 32'(dispatched_instr_valid_o), 32'd0);
      next_cycle();
      @(negedge clk);
      checkOutput("deq_release", 32'(dispatched_instr_valid_o), 32'b0100);
      next_cycle();
      @(negedge clk);
      checkOutput("deq_ready", 32'(in_ready_o), 32'd1);
      next_cycle();
      expect_idle("cred_zero", 3);

      // all EUs full: stall count, then release EU1 only, then rr lands on EU2
      do_reset();
      eu_enable_i = 4'b1111;
      eu_full_i   = 4'b1111;
      applyStimulus(8'd7, 1);
      repeat (5) next_cycle();
      @(negedge clk);
      checkOutput("full_stall", 32'(dispatch_stall_cnt_o), 32'd5);
      checkOutput("full_valid", 32'(dispatched_instr_valid_o), 32'd0);
      eu_full_i = 4'b1101;
      next_cycle();
      wait_drain("full_drain");
      eu_full_i = 4'b0000;
      applyStimulus(8'd8, 2);
      wait_drain("rr2_drain");
      checkOutput("full_stall_hold", 32'(dispatch_stall_cnt_o), 32'd5);

      // dispatch and dequeue on EU0 in the same cycle keep credit at 1
      do_reset();
      eu_enable_i = 4'b0001;
      applyStimulus(8'd11, 0);
      wait_drain("same_drain1");
      applyStimulus(8'd12, 0);
      eu_dequeue_i = 4'b0001;
      next_cycle();
      eu_dequeue_i = 4'b0000;
      wait_drain("same_drain2");
      applyStimulus(8'd13, 0);
      wait_drain("same_drain3");
      applyStimulus(8'd14, -1);
      expect_idle("same_exhausted", 4);

      // flush with a full buffer, then flush dropping a same-cycle accept
      do_reset();
      eu_enable_i = 4'b1111;
      eu_full_i   = 4'b1111;
      applyStimulus(8'd21, -1);
      applyStimulus(8'd22, -1);
      in_instr_i.tag = 8'd23;
      in_valid_i     = 1'b1;
      flush_i        = 1'b1;
      next_cycle();
      flush_i    = 1'b0;
      in_valid_i = 1'b0;
      @(negedge clk);
      checkOutput("flush_valid", 32'(dispatched_instr_valid_o), 32'd0);
      checkOutput("flush_ready", 32'(in_ready_o), 32'd1);
      next_cycle();
      applyStimulus(8'd24, -1);
      in_instr_i.tag = 8'd25;
      in_valid_i     = 1'b1;
      flush_i        = 1'b1;
      next_cycle();
      flush_i    = 1'b0;
      in_valid_i = 1'b0;
      eu_full_i  = 4'b0000;
      expect_idle("flush_idle", 4);
      for (int t = 0; t < 8; t++)
         applyStimulus(8'(30 + t), t % NEU);
      wait_drain("flush_credits");

      // reset during a stall restores credits, rr pointer and empties buffer
      do_reset();
      eu_enable_i = 4'b0010;
      applyStimulus(8'd41, 1);
      applyStimulus(8'd42, 1);
      applyStimulus(8'd43, -1);
      wait_drain("pre_rst_drain");
      repeat (3) next_cycle();
      reset          = 1'b1;
      in_instr_i.tag = 8'd44;
      in_valid_i     = 1'b1;
      next_cycle();
      reset      = 1'b0;
      in_valid_i = 1'b0;
      exp_q.delete();
      @(negedge clk);
      checkOutput("mid_rst_stall", 32'(dispatch_stall_cnt_o), 32'd0);
      checkOutput("mid_rst_ready", 32'(in_ready_o), 32'd1);
      checkOutput("mid_rst_valid", 32'(dispatched_instr_valid_o), 32'd0);
      checkOutput("mid_rst_dout1", 32'(dispatched_instr_o[1]), 32'd0);
      next_cycle();
      eu_enable_i = 4'b1111;
      applyStimulus(8'd45, 0);
      wait_drain("mid_rst_rr");
      eu_enable_i = 4'b0010;
      applyStimulus(8'd46, 1);
      applyStimulus(8'd47, 1);
      wait_drain("mid_rst_credit");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
